nmi_service_ctrl: RTL and testbench
===================================

# nmi_service_ctrl

Downstream consumer of the NMI edge-detect unit's one-cycle `NMI_req` pulse. Latches each detected NMI edge into a one-deep pending slot and presents it to the CPU core with a fixed vector. Runs the accept/return handshake and blocks NMI nesting while a handler executes. Counts NMI edges lost to slot overflow and flags handlers that overrun a service-time budget.

## Interface
- `ADDR_W`, 16, width of `int_vector`
- `NMI_VECTOR`, 16'h0004, handler address driven while requesting
- `LOST_W`, 4, width of lost-request counter
- `TIMEOUT_CYC`, 1024, max cycles in service before timeout flag (>=2); counter width = $clog2(TIMEOUT_CYC+1)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `NMI_req`  in  1  one-cycle pulse per detected NMI edge, synchronous to `clk`
- `int_ack`  in  1  CPU accepts the presented NMI; meaningful only while `cpu_nmi_req`=1
- `reti`  in  1  CPU return-from-NMI-handler, one-cycle pulse
- `lost_clr`  in  1  clears `nmi_lost_cnt`
- `cpu_nmi_req`  out  1  NMI request to CPU (registered)
- `int_vector`  out  ADDR_W  `NMI_VECTOR` while `cpu_nmi_req`=1, else 0
- `nmi_active`  out  1  handler in service
- `nmi_pend`  out  1  pending slot occupied
- `nmi_lost_cnt`  out  LOST_W  saturating count of dropped NMI edges
- `nmi_timeout`  out  1  sticky: a handler exceeded TIMEOUT_CYC

## Operation
- FSM states: IDLE (no handler running), SERVICE (handler running). Reset -> IDLE.
- Pending slot `nmi_pend`: set by `NMI_req`; cleared on acceptance.
- `cpu_nmi_req` = registered (`nmi_pend` && state==IDLE), recomputed from next-state values. No NMI nesting.
- Acceptance: `int_ack`=1 while `cpu_nmi_req`=1 -> clear pend, IDLE->SERVICE, `nmi_active`=1, timeout counter loads 0.
- `int_ack` while `cpu_nmi_req`=0 -> ignored.
- SERVICE: `reti` -> IDLE, `nmi_active`=0. `reti` in IDLE -> ignored.
- `NMI_req` during SERVICE with slot empty -> sets pend; re-presented after `reti`.
- `NMI_req` with slot full and no same-cycle acceptance -> edge dropped, `nmi_lost_cnt`+1, saturating at 2^LOST_W-1.
- `NMI_req` same cycle as acceptance -> not lost; pend stays 1 (new request), state SERVICE.
- `lost_clr` with simultaneous drop -> count = 1 (clear, then increment). `lost_clr` alone -> 0.
- Timeout counter increments every SERVICE cycle, saturating at TIMEOUT_CYC. Reaching TIMEOUT_CYC sets `nmi_timeout`, cleared only by reset. State is unaffected; `reti` still required.
- `reti` same cycle as `NMI_req` with slot empty -> IDLE, pend=1, `cpu_nmi_req`=1 next cycle.

## Timing
- Reset: all outputs 0, state IDLE, counters 0. Asynchronous assert; deassertion is synchronized externally. Reset mid-operation drops the pending request and ends service silently.
- `NMI_req` at edge n -> `nmi_pend`, `cpu_nmi_req`, `int_vector` valid after edge n+1 (1-cycle latency).
- `int_ack` sampled at edge m -> `cpu_nmi_req`=0, `nmi_active`=1 after edge m. `int_vector` returns to 0 at the same edge.
- `reti` at edge k -> `nmi_active`=0 after k. If pend=1, `cpu_nmi_req`=1 after k.
- Timeout: flag rises TIMEOUT_CYC cycles after the accept edge, if no `reti` has arrived.
- All outputs registered; no combinational input->output paths.

## Test plan
- Reset, pulse `NMI_req`@c5 -> `cpu_nmi_req`=1, `int_vector`=16'h0004 from c6; `int_ack`@c8 -> `nmi_active`=1, `cpu_nmi_req`=0 from c9; `reti`@c20 -> all outputs 0.
- In SERVICE: `NMI_req`@c10 -> `nmi_pend`=1, `cpu_nmi_req`=0; `reti`@c15 -> `cpu_nmi_req`=1 from c16. Second `NMI_req`@c12 -> `nmi_lost_cnt`=1.
- 20 `NMI_req` pulses with slot full, LOST_W=4 -> count saturates at 15; `lost_clr` with a simultaneous drop -> 1.
- `NMI_req` in the same cycle as `int_ack` -> `nmi_active`=1, `nmi_pend`=1, `nmi_lost_cnt` unchanged.
- TIMEOUT_CYC=8: accept@c0, no `reti` -> `nmi_timeout`=1 after c8, stays 1 after a later `reti`. `int_ack`/`reti` in IDLE with no request -> no change.
- `rst_n` low mid-SERVICE with pend=1 -> all outputs 0 immediately (asynchronous). After release, no request is presented.

Source files
------------

// File: rtl/nmi_service_ctrl_if.sv
// NMI service controller bus.
// Groups the request/handshake inputs and the status outputs of nmi_service_ctrl.
//   slave  : controller side (takes NMI_req/int_ack/reti/lost_clr, drives CPU-facing outputs)
//   master : driving side (upstream edge detector + CPU core)
// ADDR_W and LOST_W must match the parameters of the attached controller.
interface nmi_service_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LOST_W = 4
);
  logic              NMI_req;
  logic              int_ack;
  logic              reti;
  logic              lost_clr;
  logic              cpu_nmi_req;
  logic [ADDR_W-1:0] int_vector;
  logic              nmi_active;
  logic              nmi_pend;
  logic [LOST_W-1:0] nmi_lost_cnt;
  logic              nmi_timeout;

  modport slave (
    input  NMI_req, int_ack, reti, lost_clr,
    output cpu_nmi_req, int_vector, nmi_active, nmi_pend, nmi_lost_cnt, nmi_timeout
  );

  modport master (
    output NMI_req, int_ack, reti, lost_clr,
    input  cpu_nmi_req, int_vector, nmi_active, nmi_pend, nmi_lost_cnt, nmi_timeout
  );
endinterface

// File: rtl/nmi_service_ctrl.sv
// NMI service controller.
// Latches NMI edge pulses into a one-deep pending slot, presents them to the CPU with a fixed
// vector, runs the accept/return handshake, blocks nesting while a handler runs, counts edges
// lost to slot overflow and flags handlers that overrun a service-time budget.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : nmi_service_ctrl_if.slave
//           in : NMI_req, int_ack, reti, lost_clr
//           out: cpu_nmi_req, int_vector, nmi_active, nmi_pend, nmi_lost_cnt, nmi_timeout
// All outputs are registered.
module nmi_service_ctrl #(
  parameter int unsigned          ADDR_W      = 16,
  parameter logic [ADDR_W-1:0]    NMI_VECTOR  = 16'h0004,
  parameter int unsigned          LOST_W      = 4,
  parameter int unsigned          TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nmi_service_ctrl_if.slave       bus
);

  localparam int unsigned         TmrW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmrW-1:0]     TmrMax = TmrW'(TIMEOUT_CYC);

  typedef enum logic [0:0] {StIdle, StService} state_e;

  state_e              state_q, state_d;
  logic                pend_q, pend_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   vec_q, vec_d;
  logic                active_q, active_d;
  logic [LOST_W-1:0]   lost_q, lost_d;
  logic [TmrW-1:0]     tmr_q, tmr_d;
  logic                timeout_q, timeout_d;

  logic                accept;
  logic                drop;
  logic [LOST_W-1:0]   lost_base;

  // req_q is only ever high in IDLE with the slot full, so it alone qualifies the ack.
  assign accept = req_q & bus.int_ack;
  // An edge arriving with the slot full is lost unless the slot is vacated this same cycle.
  assign drop   = bus.NMI_req & pend_q & ~accept;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    tmr_d     = tmr_q;
    timeout_d = timeout_q;
    lost_base = lost_q;
    lost_d    = lost_q;

    unique case (state_q)
      StIdle:    if (accept) state_d = StService;
      StService: if (bus.reti) state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    // Acceptance empties the slot, but a same-cycle edge refills it.
    if (accept) begin
      pend_d = bus.NMI_req;
    end else if (bus.NMI_req) begin
      pend_d = 1'b1;
    end

    // Clear first, then count the drop, so a simultaneous clear and drop yields 1.
    if (bus.lost_clr) lost_base = '0;
    lost_d = lost_base;
    if (drop && (lost_base != {LOST_W{1'b1}})) lost_d = lost_base + LOST_W'(1);

    if (accept) begin
      tmr_d = '0;
    end else if ((state_q == StService) && (tmr_q != TmrMax)) begin
      tmr_d = tmr_q + TmrW'(1);
    end
    if ((state_q == StService) && (tmr_d == TmrMax)) timeout_d = 1'b1;

    // Outputs are registered from next-state values so they line up with the state.
    req_d    = pend_d & (state_d == StIdle);
    vec_d    = req_d ? NMI_VECTOR : '0;
    active_d = (state_d == StService);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pend_q    <= 1'b0;
      req_q     <= 1'b0;
      vec_q     <= '0;
      active_q  <= 1'b0;
      lost_q    <= '0;
      tmr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      req_q     <= req_d;
      vec_q     <= vec_d;
      active_q  <= active_d;
      lost_q    <= lost_d;
      tmr_q     <= tmr_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.cpu_nmi_req  = req_q;
  assign bus.int_vector   = vec_q;
  assign bus.nmi_active   = active_q;
  assign bus.nmi_pend     = pend_q;
  assign bus.nmi_lost_cnt = lost_q;
  assign bus.nmi_timeout  = timeout_q;

endmodule

// File: tb/tb_nmi_service_ctrl.sv
module tb_nmi_service_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  nmi_service_ctrl_if #(.ADDR_W(16), .LOST_W(4)) bus ();

  nmi_service_ctrl #(
    .ADDR_W      (16),
    .NMI_VECTOR  (16'h0004),
    .LOST_W      (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic req, input logic [15:0] vec,
                           input logic act, input logic pend, input logic [3:0] lost,
                           input logic to);
    check({tag, ".req"},  {31'd0, bus.cpu_nmi_req}, {31'd0, req});
    check({tag, ".vec"},  {16'd0, bus.int_vector},  {16'd0, vec});
    check({tag, ".act"},  {31'd0, bus.nmi_active},  {31'd0, act});
    check({tag, ".pend"}, {31'd0, bus.nmi_pend},    {31'd0, pend});
    check({tag, ".lost"}, {28'd0, bus.nmi_lost_cnt}, {28'd0, lost});
    check({tag, ".to"},   {31'd0, bus.nmi_timeout}, {31'd0, to});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.NMI_req = 1'b0;
    bus.int_ack = 1'b0;
    bus.reti = 1'b0;
    bus.lost_clr = 1'b0;
    step();
    step();
    check_all("reset", 1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;
    step();

    // int_ack / reti in IDLE with nothing pending: ignored
    bus.int_ack = 1'b1; bus.reti = 1'b1;
    step();
    bus.int_ack = 1'b0; bus.reti = 1'b0;
    check_all("idle_ignore", 1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0);

    // Basic request / accept / return
    bus.NMI_req = 1'b1; step(); bus.NMI_req = 1'b0;
    check_all("present", 1'b1, 16'h0004, 1'b0, 1'b1, 4'd0, 1'b0);
    step();
    check_all("present_hold", 1'b1, 16'h0004, 1'b0, 1'b1, 4'd0, 1'b0);
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
    check_all("accept", 1'b0, 16'h0, 1'b1, 1'b0, 4'd0, 1'b0);
    step(); step();
    bus.reti = 1'b1; step(); bus.reti = 1'b0;
    check_all("return", 1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0);

    // Request during service is held, second one is lost, re-presented after reti
    bus.NMI_req = 1'b1; step(); bus.NMI_req = 1'b0;
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
    bus.NMI_req = 1'b1; step(); bus.NMI_req = 1'b0;
    check_all("svc_pend", 1'b0, 16'h0, 1'b1, 1'b1, 4'd0, 1'b0);
    bus.NMI_req = 1'b1; step(); bus.NMI_req = 1'b0;
    check_all("svc_lost", 1'b0, 16'h0, 1'b1, 1'b1, 4'd1, 1'b0);
    bus.reti = 1'b1; step(); bus.reti = 1'b0;
    check_all("re_present", 1'b1, 16'h0004, 1'b0, 1'b1, 4'd1, 1'b0);
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
    check_all("accept2", 1'b0, 16'h0, 1'b1, 1'b0, 4'd1, 1'b0);
    // reti together with a new edge, slot empty
    bus.reti = 1'b1; bus.NMI_req = 1'b1; step(); bus.reti = 1'b0; bus.NMI_req = 1'b0;
    check_all("reti_nmi", 1'b1, 16'h0004, 1'b0, 1'b1, 4'd1, 1'b0);

    // Saturation of lost counter with slot full
    for (int i = 0; i < 20; i++) begin
      bus.NMI_req = 1'b1; step();
    end
    bus.NMI_req = 1'b0;
    check_all("lost_sat", 1'b1, 16'h0004, 1'b0, 1'b1, 4'd15, 1'b0);
    bus.lost_clr = 1'b1; bus.NMI_req = 1'b1; step(); bus.NMI_req = 1'b0;
    check("lost_clr_drop", {28'd0, bus.nmi_lost_cnt}, 32'd1);
    step(); bus.lost_clr = 1'b0;
    check("lost_clr_only", {28'd0, bus.nmi_lost_cnt}, 32'd0);

    // Acceptance with a same-cycle edge: not lost, slot refilled
    bus.int_ack = 1'b1; bus.NMI_req = 1'b1; step(); bus.int_ack = 1'b0; bus.NMI_req = 1'b0;
    check_all("ack_nmi", 1'b0, 16'h0, 1'b1, 1'b1, 4'd0, 1'b0);

    // Timeout: flag rises 8 edges after the accept edge
    for (int i = 0; i < 7; i++) step();
    check("timeout_before", {31'd0, bus.nmi_timeout}, 32'd0);
    step();
    check("timeout_rise", {31'd0, bus.nmi_timeout}, 32'd1);
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
    check("svc_ack_ignored", {31'd0, bus.nmi_pend}, 32'd1);
    bus.reti = 1'b1; step(); bus.reti = 1'b0;
    check_all("timeout_sticky", 1'b1, 16'h0004, 1'b0, 1'b1, 4'd0, 1'b1);

    // Asynchronous reset mid-service with a pending request
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
    bus.NMI_req = 1'b1; step(); bus.NMI_req = 1'b0;
    check_all("pre_reset", 1'b0, 16'h0, 1'b1, 1'b1, 4'd0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0);
    step();
    rst_n = 1'b1;
    step(); step();
    check_all("post_reset", 1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
